bus_exec_unit: RTL and testbench
================================

# bus_exec_unit

Parametrised successor to the single-bus CPU datapath. It holds a register file, Y, Z (double width), HI and LO on one internal bus, plus a built-in control-step sequencer. Given a three-register ALU instruction, it drives the register-out, Y-in, Z-in and write-back steps itself, so the control unit no longer hand-asserts per-step strobes. It sits between the instruction decoder and the register/ALU resources of the processor core.

## Interface
Parameters:
- WIDTH, 32, data/bus width in bits (≥8, power of two)
- NUM_REGS, 16, general register count (power of two, ≥4); RW = $clog2(NUM_REGS)

Ports:
- clock  in  1  single clock, all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  request to execute {op, ra, rb, rc}; sampled only in IDLE
- op  in  4  operation code (see Operation)
- ra  in  RW  destination register
- rb  in  RW  first source (Y operand)
- rc  in  RW  second source (bus operand, shift amount)
- busy  out  1  high from the cycle after acceptance until write-back completes
- done  out  1  one-cycle pulse after the final write-back
- ld_en  in  1  external register write, honoured only in IDLE
- ld_addr  in  RW  external write index
- ld_data  in  WIDTH  external write data
- rd_addr  in  RW  debug read index
- rd_data  out  WIDTH  combinational R[rd_addr]
- hi, lo  out  WIDTH  HI/LO register contents

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV; 13–15 reserved.
- Reserved ops execute as a NOP: same state sequence, no register written, done still pulses.
- States:
  - IDLE: on start go to LOADY (capture op/ra/rb/rc into internal latches).
  - LOADY: bus=R[rb]; Y<=bus; go to EXEC.
  - EXEC: bus=R[rc]; Z<=ALU(Y,bus); go to WBLO.
  - WBLO: bus=Zlow; MUL/DIV: LO<=bus, go to WBHI; otherwise R[ra]<=bus, go to DONE.
  - WBHI: bus=Zhigh; HI<=bus; go to DONE.
  - DONE: done=1; go to IDLE.
- Unary ops (NEG, NOT) use Y only; in EXEC the bus carries R[rc], which is ignored.
- Arithmetic and width rules:
  - ADD/SUB/NEG wrap modulo 2^WIDTH; Zhigh=0 for all non-MUL/DIV ops.
  - Shift/rotate amount = R[rc][$clog2(WIDTH)-1:0].
  - MUL: signed WIDTH×WIDTH → 2·WIDTH product, {HI,LO}.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder carrying the dividend's sign.
  - Divide by zero: LO=all ones, HI=dividend.
  - Most-negative ÷ −1: LO=dividend, HI=0.
- ld_en in IDLE writes R[ld_addr] at the edge. ld_en in any other state is ignored.
- ld_en and start in the same IDLE cycle: both take effect; LOADY/EXEC read the newly loaded value.
- start outside IDLE (including DONE) is ignored; no queuing.
- ra may equal rb or rc; sources are consumed before write-back, so the result is well defined.
- Reset values: all R, Y, Z, HI, LO = 0; state IDLE; busy=0, done=0; latched op/indices = 0.
- clear mid-operation: abort at that edge; no destination, HI or LO is written.

## Timing
- Start accepted at edge k.
- Non-MUL/DIV: R[ra] written at edge k+3; done high during cycle k+3→k+4; busy high during cycles k→k+3.
- MUL/DIV: LO written at k+3, HI at k+4; done high during k+4→k+5.
- Next start is accepted at the earliest in the cycle after done (IDLE), giving a throughput of one op per 5 cycles (6 for MUL/DIV).
- rd_data, hi and lo reflect register contents with no added latency; a write at an edge is visible immediately after that edge.

## Configuration
- R0_ZERO_EN defined: R0 always reads 0 (bus, rd_data); writes to R0 via write-back or ld are discarded; done still pulses.
- R0_ZERO_EN undefined: R0 is an ordinary register.

## Structure
- Package bus_exec_pkg holds:
  - op_t enum (4-bit codes above)
  - state_t enum (IDLE, LOADY, EXEC, WBLO, WBHI, DONE)
  - the OP_RESERVED_MIN constant
- Sub-module bus_alu: combinational, parameter WIDTH, inputs A, B, op; output C[2·WIDTH-1:0]. Instantiated once.
- Register file, bus mux and sequencer live in bus_exec_unit.

## Test plan
- Load R2=5, R3=7; ADD ra=1,rb=2,rc=3 → R1=12 at edge k+3, done one cycle, busy high for 4 cycles.
- Load R4=0xFFFF_FFFE, R5=3 (WIDTH=32); MUL → HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; done at k+4.
- DIV with R6=−7, R7=2 → LO=−3, HI=−1; then R7=0 → LO=0xFFFF_FFFF, HI=−7.
- ROR R8=0x8000_0001 by R9=0x21 (amount 1) → 0xC000_0000; SHRA 0x8000_0000 by 4 → 0xF800_0000.
- Assert clear during EXEC of ADD into R1 (R1 preloaded 9) → R1=0 (reset), done never pulses, next start works normally.
- With R0_ZERO_EN: ld R0=0x55 then ADD ra=0 → rd_data(R0)=0; without the macro → R0 holds the value written.

Source files
------------

// File: rtl/bus_exec_pkg.sv
// Shared types for the bus execution unit: operation codes, sequencer states
// and the first reserved opcode.
package bus_exec_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SHR  = 4'd4,
      OP_SHRA = 4'd5,
      OP_SHL  = 4'd6,
      OP_ROR  = 4'd7,
      OP_ROL  = 4'd8,
      OP_NEG  = 4'd9,
      OP_NOT  = 4'd10,
      OP_MUL  = 4'd11,
      OP_DIV  = 4'd12
   } op_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOADY = 3'd1,
      EXEC  = 3'd2,
      WBLO  = 3'd3,
      WBHI  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [3:0] OP_RESERVED_MIN = 4'd13;

   function automatic logic is_muldiv(input logic [3:0] op_code);
      return (op_code == OP_MUL) || (op_code == OP_DIV);
   endfunction

endpackage

// File: rtl/bus_alu.sv
// Combinational ALU for the bus execution unit. Result is double width so
// MUL/DIV can return {HI, LO}; the upper half is zero for every other op.
module bus_alu
   import bus_exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [3:0]         op,
   output logic [2*WIDTH-1:0] C
);

   localparam int SW = $clog2(WIDTH);

   logic [SW-1:0]          amt;
   logic [2*WIDTH-1:0]     a_dbl;
   logic [2*WIDTH-1:0]     prod;
   logic [WIDTH-1:0]       res_lo;
   logic [WIDTH-1:0]       most_neg;
   logic [WIDTH-1:0]       all_ones;
   logic signed [WIDTH-1:0] quot;
   logic signed [WIDTH-1:0] rem;

   assign amt      = B[SW-1:0];
   assign a_dbl    = {A, A};
   assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
   assign all_ones = '1;
   // Product of the sign-extended operands, truncated to 2*WIDTH, is the signed product.
   assign prod     = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};

   always_comb begin
      quot = '0;
      rem  = '0;
      if (B == '0) begin
         quot = all_ones;
         rem  = A;
      end else if ((A == most_neg) && (B == all_ones)) begin
         quot = A;
         rem  = '0;
      end else begin
         quot = $signed(A) / $signed(B);
         rem  = $signed(A) % $signed(B);
      end
   end

   always_comb begin
      res_lo = '0;
      case (op)
         OP_ADD:  res_lo = A + B;
         OP_SUB:  res_lo = A - B;
         OP_AND:  res_lo = A & B;
         OP_OR:   res_lo = A | B;
         OP_SHR:  res_lo = A >> amt;
         OP_SHRA: res_lo = $signed(A) >>> amt;
         OP_SHL:  res_lo = A << amt;
         OP_ROR:  res_lo = WIDTH'(a_dbl >> amt);
         // Rotate left by n is rotate right by WIDTH-n; n=0 shifts by WIDTH and yields A.
         OP_ROL:  res_lo = WIDTH'(a_dbl >> (WIDTH - int'(amt)));
         OP_NEG:  res_lo = -A;
         OP_NOT:  res_lo = ~A;
         default: res_lo = '0;
      endcase
   end

   always_comb begin
      C = {{WIDTH{1'b0}}, res_lo};
      if (op == OP_MUL) C = prod;
      else if (op == OP_DIV) C = {rem, quot};
   end

endmodule

// File: rtl/bus_exec_unit.sv
// Single-bus datapath (register file, Y, Z, HI, LO) with a built-in sequencer
// for three-register ALU ops. Define R0_ZERO_EN to hardwire R0 to zero.
//
// state | meaning
// IDLE  | waiting for start; external loads honoured
// LOADY | bus = R[rb], Y <= bus
// EXEC  | bus = R[rc], Z <= ALU(Y, bus)
// WBLO  | bus = Zlow; LO (MUL/DIV) or R[ra] <= bus
// WBHI  | bus = Zhigh; HI <= bus (MUL/DIV only)
// DONE  | done pulse, back to IDLE
module bus_exec_unit
   import bus_exec_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int NUM_REGS = 16,
   localparam int RW       = $clog2(NUM_REGS)
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [RW-1:0]    ra,
   input  logic [RW-1:0]    rb,
   input  logic [RW-1:0]    rc,
   output logic             busy,
   output logic             done,
   input  logic             ld_en,
   input  logic [RW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [RW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   state_t state, state_nxt;

   logic [3:0]         op_q;
   logic [RW-1:0]      ra_q, rb_q, rc_q;
   logic [WIDTH-1:0]   regs [NUM_REGS];
   logic [WIDTH-1:0]   y_q, hi_q, lo_q, bus;
   logic [2*WIDTH-1:0] z_q, alu_c;
   logic               accept, y_ld, z_ld, lo_ld, hi_ld, r_wr, ld_ok;

   function automatic logic [WIDTH-1:0] reg_rd(input logic [RW-1:0] idx);
      if (R0_ZERO && (idx == '0)) return '0;
      return regs[idx];
   endfunction

   function automatic logic reg_writable(input logic [RW-1:0] idx);
      return !(R0_ZERO && (idx == '0));
   endfunction

   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LOADY;
         LOADY:   state_nxt = EXEC;
         EXEC:    state_nxt = WBLO;
         WBLO:    state_nxt = is_muldiv(op_q) ? WBHI : DONE;
         WBHI:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus    = '0;
      busy   = (state != IDLE);
      done   = (state == DONE);
      accept = 1'b0;
      ld_ok  = 1'b0;
      y_ld   = 1'b0;
      z_ld   = 1'b0;
      lo_ld  = 1'b0;
      hi_ld  = 1'b0;
      r_wr   = 1'b0;
      case (state)
         IDLE: begin
            accept = start;
            ld_ok  = ld_en;
         end
         LOADY: begin
            bus  = reg_rd(rb_q);
            y_ld = 1'b1;
         end
         EXEC: begin
            bus  = reg_rd(rc_q);
            z_ld = 1'b1;
         end
         WBLO: begin
            bus = z_q[WIDTH-1:0];
            // Reserved opcodes walk the same states but write nothing.
            if (is_muldiv(op_q))              lo_ld = 1'b1;
            else if (op_q < OP_RESERVED_MIN)  r_wr  = 1'b1;
         end
         WBHI: begin
            bus   = z_q[2*WIDTH-1:WIDTH];
            hi_ld = 1'b1;
         end
         default: ;
      endcase
   end

   bus_alu #(.WIDTH(WIDTH)) u_alu (
      .A  (y_q),
      .B  (bus),
      .op (op_q),
      .C  (alu_c)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         op_q <= '0;
         ra_q <= '0;
         rb_q <= '0;
         rc_q <= '0;
         y_q  <= '0;
         z_q  <= '0;
         hi_q <= '0;
         lo_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (accept) begin
            op_q <= op;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
         end
         if (y_ld)  y_q  <= bus;
         if (z_ld)  z_q  <= alu_c;
         if (lo_ld) lo_q <= bus;
         if (hi_ld) hi_q <= bus;
         if (ld_ok && reg_writable(ld_addr)) regs[ld_addr] <= ld_data;
         if (r_wr && reg_writable(ra_q))     regs[ra_q]    <= bus;
      end
   end

   assign rd_data = reg_rd(rd_addr);
   assign hi      = hi_q;
   assign lo      = lo_q;

endmodule

// File: tb/tb_bus_exec_unit.sv
// Directed bench for bus_exec_unit: table of ALU vectors plus hand-written
// sequences for load/start overlap, ignored requests, mid-op clear and R0.
module tb_bus_exec_unit;
   import bus_exec_pkg::*;

   localparam int WIDTH    = 32;
   localparam int NUM_REGS = 16;
   localparam int RW       = 4;

   logic             clock = 1'b0;
   logic             clear = 1'b1;
   logic             start = 1'b0;
   logic [3:0]       op = '0;
   logic [RW-1:0]    ra = '0, rb = '0, rc = '0;
   logic             busy, done;
   logic             ld_en = 1'b0;
   logic [RW-1:0]    ld_addr = '0;
   logic [WIDTH-1:0] ld_data = '0;
   logic [RW-1:0]    rd_addr = '0;
   logic [WIDTH-1:0] rd_data, hi, lo;

   int checks = 0;
   int errors = 0;

   bus_exec_unit #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) dut (
      .clock(clock), .clear(clear), .start(start), .op(op),
      .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
      bit          md;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [RW-1:0] addr, input logic [31:0] data);
      ld_en   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic read_reg(input logic [RW-1:0] addr, output logic [31:0] val);
      rd_addr = addr;
      #1;
      val = rd_data;
   endtask

   // exp_len: edges after acceptance until done is high (3, or 4 for MUL/DIV)
   task automatic run_op(input string name, input logic [3:0] o, input logic [RW-1:0] a,
                         input logic [RW-1:0] b, input logic [RW-1:0] c,
                         input logic [31:0] old_val, input int exp_len);
      int n;
      int busy_cnt;
      bit seen;
      op = o; ra = a; rb = b; rc = c; rd_addr = a;
      start = 1'b1;
      tick();
      start = 1'b0;
      ld_en = 1'b0;
      n = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && n < 10) begin
         if (busy) busy_cnt++;
         if (done) seen = 1'b1;
         else begin
            if (n == 2) check({name, " pre-writeback"}, rd_data, old_val);
            tick();
            n++;
         end
      end
      check({name, " done latency"}, seen ? n : 99, exp_len);
      check({name, " busy cycles"}, busy_cnt, exp_len + 1);
      tick();
      check({name, " idle after done"}, {busy, done}, 2'b00);
   endtask

   initial begin
      logic [31:0] v;
      int dcnt;
      logic [31:0] r0_exp;

      vecs[0]  = '{OP_ADD,  32'd5,          32'd7,          32'd12,         32'h0,          1'b0};
      vecs[1]  = '{OP_SUB,  32'd5,          32'd7,          32'hFFFF_FFFE,  32'h0,          1'b0};
      vecs[2]  = '{OP_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  32'h0,          1'b0};
      vecs[3]  = '{OP_OR,   32'hF0F0_1234,  32'h0FF0_FF00,  32'hFFF0_FF34,  32'h0,          1'b0};
      vecs[4]  = '{OP_SHR,  32'h8000_0000,  32'd4,          32'h0800_0000,  32'h0,          1'b0};
      vecs[5]  = '{OP_SHRA, 32'h8000_0000,  32'd4,          32'hF800_0000,  32'h0,          1'b0};
      vecs[6]  = '{OP_SHL,  32'h0000_0001,  32'd35,         32'h0000_0008,  32'h0,          1'b0};
      vecs[7]  = '{OP_ROR,  32'h8000_0001,  32'h21,         32'hC000_0000,  32'h0,          1'b0};
      vecs[8]  = '{OP_ROR,  32'h1234_5678,  32'h20,         32'h1234_5678,  32'h0,          1'b0};
      vecs[9]  = '{OP_ROL,  32'h8000_0001,  32'd4,          32'h0000_0018,  32'h0,          1'b0};
      vecs[10] = '{OP_NEG,  32'd5,          32'h1234,       32'hFFFF_FFFB,  32'h0,          1'b0};
      vecs[11] = '{OP_NOT,  32'h0F0F_0000,  32'h0,          32'hF0F0_FFFF,  32'h0,          1'b0};
      vecs[12] = '{OP_MUL,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFA,  32'hFFFF_FFFF,  1'b1};
      vecs[13] = '{OP_MUL,  32'd7,          32'd6,          32'h0000_002A,  32'h0,          1'b1};
      vecs[14] = '{OP_MUL,  32'h8000_0000,  32'h8000_0000,  32'h0,          32'h4000_0000,  1'b1};
      vecs[15] = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b1};
      vecs[16] = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1};
      vecs[17] = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b1};
      vecs[18] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h1,          1'b1};
      vecs[19] = '{4'd13,   32'd5,          32'd7,          32'hDEAD_BEEF,  32'h0,          1'b0};
      vecs[20] = '{4'd15,   32'd5,          32'd7,          32'hDEAD_BEEF,  32'h0,          1'b0};

      // Reset state
      tick();
      tick();
      clear = 1'b0;
      rd_addr = 4'd1;
      #1;
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      check("reset R1", rd_data, 32'h0);
      tick();

      // Table-driven ALU vectors: R1 <= op(R2, R3)
      for (int i = 0; i < 21; i++) begin
         load(4'd1, 32'hDEAD_BEEF);
         load(4'd2, vecs[i].a);
         load(4'd3, vecs[i].b);
         run_op($sformatf("vec%0d", i), vecs[i].op, 4'd1, 4'd2, 4'd3,
                32'hDEAD_BEEF, vecs[i].md ? 4 : 3);
         read_reg(4'd1, v);
         if (vecs[i].md) begin
            check($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
            check($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d R1 untouched", i), v, 32'hDEAD_BEEF);
         end else begin
            check($sformatf("vec%0d R1", i), v, vecs[i].exp_lo);
         end
      end

      // Load and start in the same IDLE cycle: Y sees the freshly loaded R2
      load(4'd3, 32'd7);
      ld_en = 1'b1; ld_addr = 4'd2; ld_data = 32'd100;
      run_op("ld+start", OP_ADD, 4'd4, 4'd2, 4'd3, 32'h0, 3);
      read_reg(4'd4, v);
      check("ld+start R4", v, 32'd107);

      // Loads and starts while busy (through DONE) are ignored
      op = OP_ADD; ra = 4'd6; rb = 4'd2; rc = 4'd3;
      start = 1'b1;
      tick();
      ld_en = 1'b1; ld_addr = 4'd5; ld_data = 32'h77;
      for (int i = 0; i < 4; i++) tick();
      start = 1'b0;
      ld_en = 1'b0;
      check("start in DONE ignored", busy, 1'b0);
      read_reg(4'd5, v);
      check("ld while busy ignored", v, 32'h0);
      read_reg(4'd6, v);
      check("busy-window op R6", v, 32'd107);

      // Destination equal to source
      run_op("ra=rb", OP_ADD, 4'd2, 4'd2, 4'd3, 32'd100, 3);
      read_reg(4'd2, v);
      check("ra=rb R2", v, 32'd107);

      // Clear during EXEC aborts and resets
      load(4'd1, 32'd9);
      op = OP_ADD; ra = 4'd1; rb = 4'd2; rc = 4'd3; rd_addr = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear R1", rd_data, 32'h0);
      check("clear busy", busy, 1'b0);
      dcnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) dcnt++;
         tick();
      end
      check("clear no done", dcnt, 0);
      load(4'd2, 32'd5);
      load(4'd3, 32'd7);
      run_op("after clear", OP_ADD, 4'd1, 4'd2, 4'd3, 32'h0, 3);
      check("after clear R1", rd_data, 32'd12);

      // R0 behaviour depends on build configuration
`ifdef R0_ZERO_EN
      r0_exp = 32'h0;
`else
      r0_exp = 32'h55;
`endif
      load(4'd0, 32'h55);
      read_reg(4'd0, v);
      check("R0 after ld", v, r0_exp);
`ifdef R0_ZERO_EN
      run_op("R0 add", OP_ADD, 4'd0, 4'd2, 4'd3, 32'h0, 3);
      check("R0 after add", rd_data, 32'h0);
`else
      run_op("R0 add", OP_ADD, 4'd0, 4'd2, 4'd3, 32'h55, 3);
      check("R0 after add", rd_data, 32'd12);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
